// File: rtl/mem_seq_pkg.sv
// Shared types, constants and sizing helpers for the multi-cycle memory sequencer.
package mem_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StIfReq,
        StIfWait,
        StExec,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StCommit,
        StHalt
    } mem_seq_state_e;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    function automatic int unsigned timer_w(int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/mem_seq_watchdog.sv
// Per-state watchdog: counts cycles spent in a request/wait state and flags a hung handshake.
module mem_seq_watchdog
    import mem_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = timer_w(TIMEOUT);

    logic [CntW-1:0] cnt_q;

    // Saturates once expired so a held-off FSM cannot wrap the count.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_seq_fsm.sv
// Multi-cycle memory sequencer: fetch on imem, then optional read and/or write on dmem,
// stalling the core until every access has completed.
module mem_seq_fsm
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MASK_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              re_mem,
    input  logic              we_mem,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              imem_rreq_valid,
    input  logic              imem_rreq_ready,
    output logic [ADDR_W-1:0] imem_raddr,
    input  logic              imem_rrsp_valid,
    output logic              imem_rrsp_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_rreq_valid,
    input  logic              dmem_rreq_ready,
    output logic [ADDR_W-1:0] dmem_raddr,
    input  logic              dmem_rrsp_valid,
    output logic              dmem_rrsp_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_wreq_valid,
    input  logic              dmem_wreq_ready,
    output logic [ADDR_W-1:0] dmem_waddr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [MASK_W-1:0] dmem_wmask,
    input  logic              dmem_wrsp_valid,
    output logic              dmem_wrsp_ready,
    output logic [31:0]       inst,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err
);

    mem_seq_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              we_q;
    logic              wd_clr, wd_en, wd_expired;
    logic              unused_pc_lsb;

    // PC is frozen by stall, so the fetch address can follow it directly.
    assign imem_raddr    = {pc[ADDR_W-1:3], 3'b000};
    assign dmem_raddr    = addr_q;
    assign dmem_waddr    = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_wmask    = wmask_q;
    assign unused_pc_lsb = ^pc[1:0];

    assign wd_en  = state_q inside {StIfReq, StIfWait, StRdReq, StRdWait, StWrReq, StWrWait};
    assign wd_clr = (state_d != state_q);

    mem_seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StIfReq;
            StIfReq:  if (imem_rreq_valid && imem_rreq_ready) state_d = StIfWait;
            StIfWait: if (imem_rrsp_valid && imem_rrsp_ready) state_d = StExec;
            StExec: begin
                if (re_mem)      state_d = StRdReq;
                else if (we_mem) state_d = StWrReq;
                else             state_d = StCommit;
            end
            StRdReq:  if (dmem_rreq_valid && dmem_rreq_ready) state_d = StRdWait;
            StRdWait: begin
                if (dmem_rrsp_valid && dmem_rrsp_ready) state_d = we_q ? StWrReq : StCommit;
            end
            StWrReq:  if (dmem_wreq_valid && dmem_wreq_ready) state_d = StWrWait;
            StWrWait: if (dmem_wrsp_valid && dmem_wrsp_ready) state_d = StCommit;
            StCommit: state_d = StIfReq;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
        if (wd_expired && (state_d == state_q)) state_d = StHalt;
    end

    // Outputs are decoded from the next state so they are registered and line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            imem_rreq_valid <= 1'b0;
            imem_rrsp_ready <= 1'b0;
            dmem_rreq_valid <= 1'b0;
            dmem_rrsp_ready <= 1'b0;
            dmem_wreq_valid <= 1'b0;
            dmem_wrsp_ready <= 1'b0;
            stall           <= 1'b1;
            err             <= 1'b0;
            inst            <= NOP_INST;
            rdata           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            we_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            imem_rreq_valid <= (state_d == StIfReq);
            imem_rrsp_ready <= (state_d == StIfWait);
            dmem_rreq_valid <= (state_d == StRdReq);
            dmem_rrsp_ready <= (state_d == StRdWait);
            dmem_wreq_valid <= (state_d == StWrReq);
            dmem_wrsp_ready <= (state_d == StWrWait);
            stall           <= (state_d != StCommit);
            if (state_d == StHalt) err <= 1'b1;
            if (imem_rrsp_valid && imem_rrsp_ready) begin
                inst <= pc[2] ? imem_rdata[63:32] : imem_rdata[31:0];
            end
            if (state_q == StExec) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                wmask_q <= d_wmask;
                we_q    <= we_mem;
            end
            if (dmem_rrsp_valid && dmem_rrsp_ready) rdata <= dmem_rdata;
        end
    end

endmodule

// File: doc/mem_seq_fsm.md
# mem_seq_fsm

Multi-cycle memory sequencer for the RV64 core. Once per instruction it issues the instruction fetch on the imem channel, then the data read and/or write on the dmem channel. It holds `stall` high to freeze the PC and register file until every access has completed. It replaces the single-cycle always-valid memory hookup with full valid/ready handshakes, configurable widths, back-to-back read-then-write (AMO-style) sequencing, and a watchdog that halts the core on a hung memory.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: memory beat width; multiple of 32, ≥64.
- `MASK_W`, default `DATA_W/8`: byte-enable width.
- `TIMEOUT`, default 255: maximum cycles in any single request/wait state; 0 disables the watchdog.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `pc`, in, ADDR_W: current PC from the core.
- `re_mem` / `we_mem`, in, 1 each: decoded load/store for the instruction held in `inst`.
- `d_addr`, in, ADDR_W: data address (ALU result).
- `d_wdata`, in, DATA_W: aligned store data.
- `d_wmask`, in, MASK_W: store byte mask.
- `imem_rreq_valid`, out, 1: imem read request valid. `imem_rreq_ready`, in, 1: imem read request ready. `imem_raddr`, out, ADDR_W: imem read address.
- `imem_rrsp_valid`, in, 1: imem read response valid. `imem_rrsp_ready`, out, 1: imem read response ready. `imem_rdata`, in, DATA_W: imem read data.
- `dmem_rreq_valid`, out, 1: dmem read request valid. `dmem_rreq_ready`, in, 1: dmem read request ready. `dmem_raddr`, out, ADDR_W: dmem read address.
- `dmem_rrsp_valid`, in, 1: dmem read response valid. `dmem_rrsp_ready`, out, 1: dmem read response ready. `dmem_rdata`, in, DATA_W: dmem read data.
- `dmem_wreq_valid`, out, 1: dmem write request valid. `dmem_wreq_ready`, in, 1: dmem write request ready. `dmem_waddr`, out, ADDR_W: write address. `dmem_wdata`, out, DATA_W: write data. `dmem_wmask`, out, MASK_W: write byte mask.
- `dmem_wrsp_valid`, in, 1: dmem write response valid. `dmem_wrsp_ready`, out, 1: dmem write response ready.
- `inst`, out, 32: latched instruction.
- `rdata`, out, DATA_W: latched load beat.
- `stall`, out, 1: freeze the core.
- `err`, out, 1: sticky watchdog error.

## Operation
- States: IDLE, IF_REQ, IF_WAIT, EXEC, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, COMMIT, HALT.
- IDLE → IF_REQ unconditionally.
- IF_REQ: `imem_rreq_valid`=1 with `imem_raddr={pc[ADDR_W-1:3],3'b0}`. On ready → IF_WAIT.
- IF_WAIT: `imem_rrsp_ready`=1. On valid, latch `inst`: `imem_rdata[63:32]` if `pc[2]`, otherwise `[31:0]` (upper beat lanes above 64 ignored). → EXEC.
- EXEC: one decode cycle. Latch `d_addr`, `d_wdata`, `d_wmask`. Then:
  - `re_mem` → RD_REQ;
  - else `we_mem` → WR_REQ;
  - else → COMMIT.
- RD_REQ: on ready → RD_WAIT.
- RD_WAIT: on response, latch `rdata`. Then → WR_REQ if the latched `we_mem` was set, otherwise → COMMIT.
- WR_REQ: on ready → WR_WAIT.
- WR_WAIT: on response → COMMIT. The response carries no data.
- COMMIT: `stall`=0 for exactly one cycle, during which the core advances the PC and writes back. → IF_REQ.
- `stall`=1 in every state except COMMIT.
- Request valid is asserted only in its REQ state. Address, data and mask are stable while valid is asserted. Valid never drops before ready.
- Response-ready is asserted only in the matching WAIT state. A response arriving in any other state is not accepted.
- Watchdog: the counter clears on every state change and increments each cycle in a REQ/WAIT state. When it reaches TIMEOUT without the handshake completing → HALT, and `err` is set (sticky). HALT holds `stall`=1 with all valids/readies 0 until reset.

## Timing
- Reset values:
  - state = IDLE;
  - all valids and readies = 0;
  - `stall`=1;
  - `err`=0;
  - `inst`=32'h00000013;
  - `rdata`=0;
  - watchdog counter = 0.
- A handshake completes in the cycle where valid and ready are both 1. The next state is entered on the following edge.
- Zero-wait memory: ready is 1 and the response is valid in the cycle after acceptance. Cycle counts:
  - ALU/branch: IF_REQ, IF_WAIT, EXEC, COMMIT = 4 cycles;
  - load only: 6 cycles;
  - store only: 6 cycles;
  - load+store: 8 cycles.
- Each wait cycle on ready or response adds exactly one cycle.
- Reset asserted mid-transaction aborts on the next edge. Outstanding memory responses are the memory model's responsibility and are dropped.
- `inst` and `rdata` hold their value until overwritten. `rdata` remains valid through COMMIT.

## Structure
- Package `mem_seq_pkg` holds:
  - the `mem_seq_state_e` enum;
  - the `NOP_INST` constant (32'h00000013);
  - the `timer_w(TIMEOUT)` width function, which returns `$clog2(TIMEOUT+1)` with a minimum of 1.
- Sub-module `mem_seq_watchdog` holds the counter, the clear/enable inputs, and the `expired` output, which is tied to 0 when TIMEOUT=0.
- The FSM and output decode stay in `mem_seq_fsm`.

## Test plan
- ALU instruction, zero-wait memory, `pc`=0x4, `imem_rdata`=0x00A00093_00000013 → `inst`=0x00A00093; `stall` low for exactly cycle 4 after reset release; no dmem activity.
- Load, `d_addr`=0x1008, `dmem_rdata`=0xDEADBEEF_CAFEF00D, `rreq_ready` delayed 3 cycles → `dmem_raddr` stable at 0x1008 for all 4 valid cycles; `rdata` latched; COMMIT at cycle 9.
- Store, `d_wmask`=0x0F, `d_wdata`=0x12345678 → a single write with matching addr/data/mask; 6-cycle instruction.
- `re_mem`=`we_mem`=1 → read completes before `dmem_wreq_valid` rises; 8 cycles total.
- TIMEOUT=4, `imem_rreq_ready` stuck 0 → HALT after 4 cycles in IF_REQ; `err`=1; `stall`=1; all valids 0 until `rst` clears `err`.
- `rst` pulsed while in RD_WAIT → next cycle IDLE, all valids 0; normal fetch restarts afterward.
